dram_ctrl: RTL and testbench

Synchronous initiator for the asynchronous multiplexed-address DRAM SIMM models (64K/256K/1M byte). Converts a single-word host request/acknowledge handshake into row/column strobe sequences (*RAS, *CAS, *WE, multiplexed RA, bidirectional RDQ) and, optionally, issues RAS-only refresh. Sits between the bus-bridge logic and the DRAM SIMM in the bring-up board FPGA.

---
 rtl/dram_pkg.sv | 37 +++
 rtl/dram_refresh_timer.sv | 52 +++++
 rtl/dram_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_dram_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// ----------------------------------------------------------------------------
// dram_pkg
// Shared definitions for the DRAM SIMM initiator:
//   - state_t       : controller FSM state encoding
//   - DRAM_*        : default geometry and timing constants
//   - CNT_W         : width of the per-state cycle counter
//   - cnt_load()    : converts a cycle count into a down-counter load value
// ----------------------------------------------------------------------------
package dram_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RAS_SETUP,
      ST_RAS,
      ST_CAS_SETUP,
      ST_CAS,
      ST_PRE,
      ST_REF_SETUP,
      ST_REF_RAS
   } state_t;

   localparam int unsigned DRAM_RASBITS      = 8;
   localparam int unsigned DRAM_WORDBITS     = 8;
   localparam int unsigned DRAM_TRCD         = 2;
   localparam int unsigned DRAM_TCAS         = 2;
   localparam int unsigned DRAM_TRP          = 2;
   localparam int unsigned DRAM_TRAS_REF     = 3;
   localparam int unsigned DRAM_REF_INTERVAL = 1000;

   localparam int unsigned CNT_W = 16;

   // A state lasting N cycles loads N-1 and leaves when the counter is zero.
   function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cycles);
      return CNT_W'(cycles - 32'd1);
   endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// ----------------------------------------------------------------------------
// dram_refresh_timer
// Free-running refresh interval counter, single-entry pending flag and
// RAS-only refresh row counter.
// Ports:
//   i_clk      system clock
//   i_res      synchronous active-high reset
//   i_take     controller is starting a refresh: clear pending, advance row
//   o_pending  a refresh is owed (saturates at one outstanding request)
//   o_row      row to refresh next, wraps 2**RASBITS-1 -> 0
// ----------------------------------------------------------------------------
module dram_refresh_timer
   import dram_pkg::*;
#(
   parameter int unsigned RASBITS      = DRAM_RASBITS,
   parameter int unsigned REF_INTERVAL = DRAM_REF_INTERVAL
)(
   input  logic               i_clk,
   input  logic               i_res,
   input  logic               i_take,
   output logic               o_pending,
   output logic [RASBITS-1:0] o_row
);

   logic [31:0]        r_interval;
   logic               r_pending;
   logic [RASBITS-1:0] r_row;
   logic               w_expire;

   assign w_expire = (r_interval == (REF_INTERVAL - 32'd1));

   always_ff @(posedge i_clk) begin
      if (i_res) begin
         r_interval <= '0;
         r_pending  <= 1'b0;
         r_row      <= '0;
      end else begin
         r_interval <= w_expire ? '0 : (r_interval + 32'd1);
         // A fresh expiry on the same edge as a take leaves one owed.
         if (w_expire)
            r_pending <= 1'b1;
         else if (i_take)
            r_pending <= 1'b0;
         if (i_take)
            r_row <= r_row + RASBITS'(1);
      end
   end

   assign o_pending = r_pending;
   assign o_row     = r_row;

endmodule

// File: rtl/dram_ctrl.sv
// ----------------------------------------------------------------------------
// dram_ctrl
// Synchronous initiator for asynchronous multiplexed-address DRAM SIMMs.
// Turns a single-word req/ack handshake into *RAS/*CAS/*WE sequences with a
// multiplexed row/column address, and optionally issues RAS-only refresh.
// Build option: define DRAM_CTRL_REFRESH_EN to include the refresh timer,
// REF_* states and refresh arbitration; otherwise no refresh is ever issued.
// Ports:
//   clk, res        clock, synchronous active-high reset
//   req, we         host request (level) and direction (1 = write)
//   addr            {row, column} word address
//   wdata / rdata   write data in / read data out (valid while ack)
//   ack             one-cycle completion pulse
//   busy            controller not idle
//   n_ras, n_cas,
//   n_we, ra        registered DRAM strobes and multiplexed address
//   rdq             DRAM data, driven only around the write column phase
// ----------------------------------------------------------------------------
module dram_ctrl
   import dram_pkg::*;
#(
   parameter int unsigned RASBITS      = DRAM_RASBITS,
   parameter int unsigned WORDBITS     = DRAM_WORDBITS,
   parameter int unsigned TRCD         = DRAM_TRCD,
   parameter int unsigned TCAS         = DRAM_TCAS,
   parameter int unsigned TRP          = DRAM_TRP,
   parameter int unsigned TRAS_REF     = DRAM_TRAS_REF,
   parameter int unsigned REF_INTERVAL = DRAM_REF_INTERVAL
)(
   input  logic                   clk,
   input  logic                   res,
   input  logic                   req,
   input  logic                   we,
   input  logic [2*RASBITS-1:0]   addr,
   input  logic [WORDBITS-1:0]    wdata,
   output logic [WORDBITS-1:0]    rdata,
   output logic                   ack,
   output logic                   busy,
   output logic                   n_ras,
   output logic                   n_cas,
   output logic                   n_we,
   output logic [RASBITS-1:0]     ra,
   inout  wire logic [WORDBITS-1:0] rdq
);

   state_t              r_state,   w_state_nxt;
   logic [CNT_W-1:0]    r_cnt,     w_cnt_nxt;
   logic                r_we,      w_we_nxt;
   logic [RASBITS-1:0]  r_col,     w_col_nxt;
   logic [WORDBITS-1:0] r_wdata,   w_wdata_nxt;
   logic [WORDBITS-1:0] r_rdata,   w_rdata_nxt;
   logic                r_ack,     w_ack_nxt;
   logic                r_n_ras,   w_n_ras_nxt;
   logic                r_n_cas,   w_n_cas_nxt;
   logic                r_n_we,    w_n_we_nxt;
   logic [RASBITS-1:0]  r_ra,      w_ra_nxt;
   logic                r_drive,   w_drive_nxt;
   logic                r_is_ref,  w_is_ref_nxt;

   logic                w_ref_pending;
   logic [RASBITS-1:0]  w_ref_row;
   logic                w_ref_take;

`ifdef DRAM_CTRL_REFRESH_EN
   dram_refresh_timer #(
      .RASBITS      (RASBITS),
      .REF_INTERVAL (REF_INTERVAL)
   ) u_ref_timer (
      .i_clk     (clk),
      .i_res     (res),
      .i_take    (w_ref_take),
      .o_pending (w_ref_pending),
      .o_row     (w_ref_row)
   );
`else
   localparam int unsigned unused_ref_interval = REF_INTERVAL;
   logic w_unused_ref_take;
   assign w_ref_pending     = 1'b0;
   assign w_ref_row         = '0;
   assign w_unused_ref_take = w_ref_take;
`endif

   always_ff @(posedge clk) begin
      if (res) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_we     <= 1'b0;
         r_col    <= '0;
         r_wdata  <= '0;
         r_rdata  <= '0;
         r_ack    <= 1'b0;
         r_n_ras  <= 1'b1;
         r_n_cas  <= 1'b1;
         r_n_we   <= 1'b1;
         r_ra     <= '0;
         r_drive  <= 1'b0;
         r_is_ref <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_we     <= w_we_nxt;
         r_col    <= w_col_nxt;
         r_wdata  <= w_wdata_nxt;
         r_rdata  <= w_rdata_nxt;
         r_ack    <= w_ack_nxt;
         r_n_ras  <= w_n_ras_nxt;
         r_n_cas  <= w_n_cas_nxt;
         r_n_we   <= w_n_we_nxt;
         r_ra     <= w_ra_nxt;
         r_drive  <= w_drive_nxt;
         r_is_ref <= w_is_ref_nxt;
      end
   end

   // Address changes are always scheduled one edge before the strobe that
   // captures them falls, so ra is stable across every strobe edge.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_we_nxt     = r_we;
      w_col_nxt    = r_col;
      w_wdata_nxt  = r_wdata;
      w_rdata_nxt  = r_rdata;
      w_ack_nxt    = 1'b0;
      w_n_ras_nxt  = r_n_ras;
      w_n_cas_nxt  = r_n_cas;
      w_n_we_nxt   = r_n_we;
      w_ra_nxt     = r_ra;
      w_drive_nxt  = r_drive;
      w_is_ref_nxt = r_is_ref;
      w_ref_take   = 1'b0;

      case (r_state)
         // The ack cycle is the single IDLE cycle of a back-to-back pair:
         // a req still high at its closing edge starts the next access.
         ST_IDLE: begin
            if (w_ref_pending) begin
               w_ref_take   = 1'b1;
               w_is_ref_nxt = 1'b1;
               w_ra_nxt     = w_ref_row;
               w_state_nxt  = ST_REF_SETUP;
            end else if (req) begin
               w_is_ref_nxt = 1'b0;
               w_we_nxt     = we;
               w_col_nxt    = addr[RASBITS-1:0];
               w_wdata_nxt  = wdata;
               w_ra_nxt     = addr[2*RASBITS-1:RASBITS];
               w_state_nxt  = ST_RAS_SETUP;
            end
         end

         ST_RAS_SETUP: begin
            w_n_ras_nxt = 1'b0;
            w_cnt_nxt   = cnt_load(TRCD);
            w_state_nxt = ST_RAS;
         end

         ST_RAS: begin
            if (r_cnt == '0) begin
               w_ra_nxt    = r_col;
               w_n_we_nxt  = ~r_we;
               w_drive_nxt = r_we;
               w_state_nxt = ST_CAS_SETUP;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end

         ST_CAS_SETUP: begin
            w_n_cas_nxt = 1'b0;
            w_cnt_nxt   = cnt_load(TCAS);
            w_state_nxt = ST_CAS;
         end

         ST_CAS: begin
            if (r_cnt == '0) begin
               w_n_cas_nxt = 1'b1;
               w_n_ras_nxt = 1'b1;
               w_n_we_nxt  = 1'b1;
               if (!r_we)
                  w_rdata_nxt = rdq;
               w_cnt_nxt   = cnt_load(TRP);
               w_state_nxt = ST_PRE;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end

         // Write data stays on rdq for the first precharge cycle so the
         // DRAM latching on the *CAS rise sees it stable.
         ST_PRE: begin
            w_drive_nxt = 1'b0;
            if (r_cnt == '0) begin
               w_ack_nxt   = ~r_is_ref;
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end

         ST_REF_SETUP: begin
            w_n_ras_nxt = 1'b0;
            w_cnt_nxt   = cnt_load(TRAS_REF);
            w_state_nxt = ST_REF_RAS;
         end

         ST_REF_RAS: begin
            if (r_cnt == '0) begin
               w_n_ras_nxt = 1'b1;
               w_cnt_nxt   = cnt_load(TRP);
               w_state_nxt = ST_PRE;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign rdq   = r_drive ? r_wdata : 'z;
   assign rdata = r_rdata;
   assign ack   = r_ack;
   assign busy  = (r_state != ST_IDLE);
   assign n_ras = r_n_ras;
   assign n_cas = r_n_cas;
   assign n_we  = r_n_we;
   assign ra    = r_ra;

endmodule

// File: tb/tb_dram_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dram_ctrl
// Directed bench for dram_ctrl (64K SIMM geometry, default timing) with a
// behavioural DRAM: row latched on *RAS fall, column on *CAS fall, write
// committed on *CAS rise, read data driven while *CAS low and *WE high.
// With DRAM_CTRL_REFRESH_EN defined the refresh interval is shortened to 20.
// ----------------------------------------------------------------------------
module tb_dram_ctrl;

`ifdef DRAM_CTRL_REFRESH_EN
   localparam int unsigned TB_REF_INTERVAL = 20;
`else
   localparam int unsigned TB_REF_INTERVAL = 1000;
`endif

   logic        clk = 1'b0;
   logic        res;
   logic        req;
   logic        we;
   logic [15:0] addr;
   logic [7:0]  wdata;
   logic [7:0]  rdata;
   logic        ack;
   logic        busy;
   logic        n_ras;
   logic        n_cas;
   logic        n_we;
   logic [7:0]  ra;
   wire  [7:0]  rdq;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dram_ctrl #(
      .RASBITS      (8),
      .WORDBITS     (8),
      .TRCD         (2),
      .TCAS         (2),
      .TRP          (2),
      .TRAS_REF     (3),
      .REF_INTERVAL (TB_REF_INTERVAL)
   ) dut (
      .clk   (clk),
      .res   (res),
      .req   (req),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata),
      .ack   (ack),
      .busy  (busy),
      .n_ras (n_ras),
      .n_cas (n_cas),
      .n_we  (n_we),
      .ra    (ra),
      .rdq   (rdq)
   );

   // ---------------- behavioural DRAM ----------------
   logic [7:0] mem [0:65535];
   logic [7:0] m_row = 8'h00;
   logic [7:0] m_col = 8'h00;
   logic       m_wr  = 1'b0;
   logic       probe = 1'b0;
   logic [7:0] mem_q;

   initial for (int i = 0; i < 65536; i++) mem[i] = 8'hEE;

   always @(negedge n_ras) m_row = ra;
   always @(negedge n_cas) begin
      m_col = ra;
      m_wr  = !n_we;
   end
   always @(posedge n_cas) if (m_wr) begin
      mem[{m_row, m_col}] = rdq;
      m_wr = 1'b0;
   end

   assign mem_q = mem[{m_row, m_col}];
   // probe drives a marker so an idle bus can be checked for no DUT driver
   assign rdq = (!n_cas && n_we) ? mem_q : (probe ? 8'hC3 : 8'hzz);

   // ---------------- helpers ----------------
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 40 && busy; k++) begin
         @(posedge clk); #1;
      end
      check("idle_wait_busy", busy, 0);
   endtask

   // Runs one access; lat is edges from the accept edge to the ack edge.
   task automatic access(input logic w, input logic [15:0] a, input logic [7:0] d,
                         output logic [7:0] rd, output int lat,
                         output logic [7:0] row, output logic [7:0] col,
                         output logic [7:0] frow, output int rf, output int cf);
      logic got, pr, pc;
      got = 1'b0; rd = 8'h00; lat = -1; row = 8'h00; col = 8'h00;
      frow = 8'h00; rf = 0; cf = 0;
      req = 1'b1; we = w; addr = a; wdata = d;
      pr = n_ras; pc = n_cas;
      for (int i = 0; i < 60 && !got; i++) begin
         @(posedge clk); #1;
         if (pr && !n_ras) begin
            if (rf == 0) frow = ra;
            row = ra;
            rf++;
         end
         if (pc && !n_cas) begin
            col = ra;
            cf++;
         end
         pr = n_ras; pc = n_cas;
         if (ack) begin
            got = 1'b1;
            lat = i;
            rd  = rdata;
         end
      end
      req = 1'b0;
      check("ack_seen", got, 1);
   endtask

   typedef struct {
      logic        w;
      logic [15:0] a;
      logic [7:0]  d;
      logic [7:0]  row;
      logic [7:0]  col;
      logic [7:0]  rd;
   } vec_t;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1);
   end

   initial begin
      vec_t       tbl [8];
      logic [7:0] rd, row, col, frow;
      int         lat, rf, cf;
      int         rise [8];
      int         nr, dbl, na, acks;
      logic       prev_b, prev_a, got_cas;

      tbl[0] = '{1'b1, 16'h1234, 8'hA5, 8'h12, 8'h34, 8'h00};
      tbl[1] = '{1'b0, 16'h1234, 8'h00, 8'h12, 8'h34, 8'hA5};
      tbl[2] = '{1'b1, 16'h0000, 8'h11, 8'h00, 8'h00, 8'h00};
      tbl[3] = '{1'b1, 16'h00FF, 8'h22, 8'h00, 8'hFF, 8'h00};
      tbl[4] = '{1'b0, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h11};
      tbl[5] = '{1'b0, 16'h00FF, 8'h00, 8'h00, 8'hFF, 8'h22};
      tbl[6] = '{1'b1, 16'hFF00, 8'h5A, 8'hFF, 8'h00, 8'h00};
      tbl[7] = '{1'b0, 16'hFF00, 8'h00, 8'hFF, 8'h00, 8'h5A};

      res = 1'b1; req = 1'b0; we = 1'b0; addr = 16'h0000; wdata = 8'h00;
      repeat (3) @(posedge clk);
      #1 res = 1'b0;

      // ---- reset state after 10 idle cycles ----
      probe = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("rst_n_ras", n_ras, 1);
      check("rst_n_cas", n_cas, 1);
      check("rst_n_we",  n_we,  1);
      check("rst_ra",    ra,    0);
      check("rst_ack",   ack,   0);
      check("rst_busy",  busy,  0);
      check("rst_rdata", rdata, 0);
      check("rst_rdq_released", rdq, 8'hC3);
      probe = 1'b0;

      // ---- table-driven single accesses ----
      for (int i = 0; i < 8; i++) begin
         wait_idle();
         access(tbl[i].w, tbl[i].a, tbl[i].d, rd, lat, row, col, frow, rf, cf);
         check($sformatf("v%0d_row", i), row, tbl[i].row);
         check($sformatf("v%0d_col", i), col, tbl[i].col);
         check($sformatf("v%0d_cas_falls", i), cf, 1);
`ifdef DRAM_CTRL_REFRESH_EN
         check($sformatf("v%0d_latency", i), lat, 8 + 7 * (rf - 1));
`else
         check($sformatf("v%0d_latency", i), lat, 8);
`endif
         if (!tbl[i].w)
            check($sformatf("v%0d_rdata", i), rd, tbl[i].rd);
      end

      // ---- req held high: accept spacing and single ack pulses ----
      wait_idle();
      req = 1'b1; we = 1'b0; addr = 16'h1234;
      prev_b = busy; prev_a = ack; nr = 0; dbl = 0; na = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (busy && !prev_b && nr < 8) begin
            rise[nr] = k;
            nr++;
         end
         if (ack && prev_a) dbl++;
         if (ack) begin
            na++;
            check("b2b_rdata", rdata, 8'hA5);
         end
         prev_b = busy; prev_a = ack;
      end
      req = 1'b0;
      check("b2b_double_ack", dbl, 0);
`ifdef DRAM_CTRL_REFRESH_EN
      for (int k = 1; k < nr && k < 4; k++)
         check($sformatf("b2b_gap%0d", k),
               ((rise[k] - rise[k-1]) == 9) || ((rise[k] - rise[k-1]) == 16), 1);
`else
      check("b2b_accepts", nr, 5);
      check("b2b_acks", na, 4);
      for (int k = 1; k < nr && k < 5; k++)
         check($sformatf("b2b_gap%0d", k), rise[k] - rise[k-1], 9);
`endif
      wait_idle();
      @(posedge clk); #1;

      // ---- reset while a read holds *CAS low ----
      wait_idle();
      req = 1'b1; we = 1'b0; addr = 16'h0000;
      got_cas = 1'b0;
      for (int k = 0; k < 30 && !got_cas; k++) begin
         @(posedge clk); #1;
         if (!n_cas) got_cas = 1'b1;
      end
      check("midrst_reached_cas", got_cas, 1);
      res = 1'b1; req = 1'b0;
      @(posedge clk); #1;
      check("midrst_n_ras", n_ras, 1);
      check("midrst_n_cas", n_cas, 1);
      check("midrst_n_we",  n_we,  1);
      check("midrst_ra",    ra,    0);
      check("midrst_busy",  busy,  0);
      check("midrst_ack",   ack,   0);
      check("midrst_rdata", rdata, 0);
      res = 1'b0;
      acks = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (ack) acks++;
      end
      check("midrst_no_ack", acks, 0);

      wait_idle();
      access(1'b0, 16'h00FF, 8'h00, rd, lat, row, col, frow, rf, cf);
      check("post_rst_rdata", rd, 8'h22);
      check("post_rst_col", col, 8'hFF);

`ifdef DRAM_CTRL_REFRESH_EN
      // ---- refresh pending coincides with req ----
      // Reset edge R zeroes the timer; pending rises at R+20, refresh at R+21.
      res = 1'b1;
      @(posedge clk); #1;
      res = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("ref_idle_before", busy, 0);
      access(1'b0, 16'hFF00, 8'h00, rd, lat, row, col, frow, rf, cf);
      check("ref1_row",       frow, 8'h00);
      check("ref1_ras_falls", rf,   2);
      check("ref1_cas_falls", cf,   1);
      check("ref1_latency",   lat,  15);
      check("ref1_acc_row",   row,  8'hFF);
      check("ref1_rdata",     rd,   8'h5A);
      begin
         logic       pr2;
         int         falls, cas_low;
         logic [7:0] r2;
         pr2 = n_ras; falls = 0; cas_low = 0; r2 = 8'h00;
         repeat (12) begin
            @(posedge clk); #1;
            if (pr2 && !n_ras) begin
               r2 = ra;
               falls++;
            end
            if (!n_cas) cas_low++;
            pr2 = n_ras;
         end
         check("ref2_ras_falls", falls,   1);
         check("ref2_row",       r2,      8'h01);
         check("ref2_cas_quiet", cas_low, 0);
      end
      wait_idle();
      access(1'b0, 16'h1234, 8'h00, rd, lat, row, col, frow, rf, cf);
      check("ref_retained", rd, 8'hA5);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
